fft_stage_sequencer: RTL and testbench



---
 rtl/fft_stage_sequencer_pkg.sv | 37 +++
 rtl/fft_addr_gen.sv | 18 +
 rtl/fft_stage_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the in-place radix-2 FFT control path:
// float width, sequencer state encoding and butterfly address arithmetic.
package fft_stage_sequencer_pkg;

    localparam int FW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        LAT    = 3'd2,
        GO     = 3'd3,
        WAITBF = 3'd4,
        WR     = 3'd5,
        DONE   = 3'd6
    } fft_state_t;

    // Top (port A) sample address of butterfly k in stage s.
    function automatic logic [31:0] fft_top_addr(input logic [31:0] s, input logic [31:0] k);
        logic [31:0] half_m1;
        half_m1 = (32'd1 << s) - 32'd1;
        return ((k >> s) << (s + 32'd1)) + (k & half_m1);
    endfunction

    // Bottom (port B) sample address: one half-span above the top sample.
    function automatic logic [31:0] fft_bot_addr(input logic [31:0] s, input logic [31:0] k);
        return fft_top_addr(s, k) + (32'd1 << s);
    endfunction

    // Twiddle ROM index: position inside the group scaled to the full-size table.
    function automatic logic [31:0] fft_tw_addr(input logic [31:0] s, input logic [31:0] k,
                                                input logic [31:0] logn);
        logic [31:0] half_m1;
        half_m1 = (32'd1 << s) - 32'd1;
        return (k & half_m1) << (logn - 32'd1 - s);
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational address generator: (stage, butterfly) -> sample and twiddle addresses.
module fft_addr_gen
    import fft_stage_sequencer_pkg::*;
#(
    parameter int LOGN = 6
) (
    input  logic [LOGN-1:0] s_i,
    input  logic [LOGN-2:0] k_i,
    output logic [LOGN-1:0] addr_a_o,
    output logic [LOGN-1:0] addr_b_o,
    output logic [LOGN-2:0] tw_addr_o
);

    assign addr_a_o  = LOGN'(fft_top_addr(32'(s_i), 32'(k_i)));
    assign addr_b_o  = LOGN'(fft_bot_addr(32'(s_i), 32'(k_i)));
    assign tw_addr_o = (LOGN-1)'(fft_tw_addr(32'(s_i), 32'(k_i), 32'(LOGN)));

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks an in-place decimation-in-time FFT over every stage: read a sample pair
// and twiddle, hand them to the butterfly, wait for its result, write it back.
// Butterfly handshake: bf_go pulses for one cycle with operands already stable;
// operands stay stable until the butterfly answers with a one-cycle bf_done,
// which is only honoured while waiting for it.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter  int SIZE       = 64,
    parameter  int BF_TIMEOUT = 255,
    localparam int LOGN       = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic            we_a,
    output logic            we_b,
    output logic [FW-1:0]   wdata_a_re,
    output logic [FW-1:0]   wdata_a_im,
    output logic [FW-1:0]   wdata_b_re,
    output logic [FW-1:0]   wdata_b_im,
    input  logic [FW-1:0]   rdata_a_re,
    input  logic [FW-1:0]   rdata_a_im,
    input  logic [FW-1:0]   rdata_b_re,
    input  logic [FW-1:0]   rdata_b_im,
    output logic [LOGN-2:0] tw_addr,
    input  logic [FW-1:0]   tw_cos,
    input  logic [FW-1:0]   tw_sin,
    output logic [FW-1:0]   r1,
    output logic [FW-1:0]   i1,
    output logic [FW-1:0]   r2,
    output logic [FW-1:0]   i2,
    output logic [FW-1:0]   SIN,
    output logic [FW-1:0]   COS,
    output logic            bf_go,
    input  logic            bf_done,
    input  logic [FW-1:0]   F0R,
    input  logic [FW-1:0]   F0I,
    input  logic [FW-1:0]   F1R,
    input  logic [FW-1:0]   F1I
);

    localparam int              WW        = $clog2(BF_TIMEOUT + 1);
    // Timeout fires so that done lands exactly BF_TIMEOUT cycles after bf_go
    // (BF_TIMEOUT must be at least 2).
    localparam logic [WW-1:0]   WAIT_LAST = WW'(BF_TIMEOUT - 2);
    localparam logic [LOGN-1:0] S_LAST    = LOGN'(LOGN - 1);
    localparam logic [LOGN-2:0] K_LAST    = '1;

    fft_state_t      state_q, state_d;
    logic [LOGN-1:0] s_q, s_d;
    logic [LOGN-2:0] k_q, k_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            error_q, error_d;
    logic            load_ops, load_res;

    logic [FW-1:0]   r1_q, i1_q, r2_q, i2_q, sin_q, cos_q;
    logic [FW-1:0]   wa_re_q, wa_im_q, wb_re_q, wb_im_q;

    logic [LOGN-1:0] gen_a, gen_b;
    logic [LOGN-2:0] gen_tw;

    fft_addr_gen #(.LOGN(LOGN)) u_addr_gen (
        .s_i       (s_q),
        .k_i       (k_q),
        .addr_a_o  (gen_a),
        .addr_b_o  (gen_b),
        .tw_addr_o (gen_tw)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    // Next state, stage/butterfly counters, butterfly timeout and capture strobes.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        k_d      = k_q;
        wait_d   = wait_q;
        error_d  = error_q;
        load_ops = 1'b0;
        load_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    state_d = RD;
                end
            end
            RD:  state_d = LAT;
            LAT: begin
                load_ops = 1'b1;
                state_d  = GO;
            end
            GO: begin
                wait_d  = '0;
                state_d = WAITBF;
            end
            WAITBF: begin
                if (bf_done) begin
                    load_res = 1'b1;
                    state_d  = WR;
                end else if (wait_q == WAIT_LAST) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            WR: begin
                if (k_q != K_LAST) begin
                    k_d     = k_q + 1'b1;
                    state_d = RD;
                end else begin
                    k_d = '0;
                    if (s_q != S_LAST) begin
                        s_d     = s_q + 1'b1;
                        state_d = RD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                s_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers (held through the butterfly) and write-back data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q    <= '0;
            i1_q    <= '0;
            r2_q    <= '0;
            i2_q    <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            wa_re_q <= '0;
            wa_im_q <= '0;
            wb_re_q <= '0;
            wb_im_q <= '0;
        end else begin
            if (load_ops) begin
                r1_q  <= rdata_a_re;
                i1_q  <= rdata_a_im;
                r2_q  <= rdata_b_re;
                i2_q  <= rdata_b_im;
                cos_q <= tw_cos;
                sin_q <= tw_sin;
            end
            if (load_res) begin
                wa_re_q <= F0R;
                wa_im_q <= F0I;
                wb_re_q <= F1R;
                wb_im_q <= F1I;
            end
        end
    end

    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign done  = (state_q == DONE);
    assign error = error_q;
    assign bf_go = (state_q == GO);
    // A reset arriving during WR must not let that write reach the RAM.
    assign we_a  = (state_q == WR) && !rst;
    assign we_b  = (state_q == WR) && !rst;

    assign addr_a  = busy ? gen_a  : '0;
    assign addr_b  = busy ? gen_b  : '0;
    assign tw_addr = busy ? gen_tw : '0;

    assign r1  = r1_q;
    assign i1  = i1_q;
    assign r2  = r2_q;
    assign i2  = i2_q;
    assign SIN = sin_q;
    assign COS = cos_q;

    assign wdata_a_re = wa_re_q;
    assign wdata_a_im = wa_im_q;
    assign wdata_b_re = wb_re_q;
    assign wdata_b_im = wb_im_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer at SIZE=8 with a RAM/ROM model and a
// real-arithmetic butterfly model of configurable latency.
module tb_fft_stage_sequencer;

  localparam int SZ  = 8;
  localparam int LG  = 3;
  localparam int TO  = 10;
  localparam int NBF = (SZ / 2) * LG;
  localparam logic [31:0] ONE = 32'h3f80_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          busy, done, error, we_a, we_b, bf_go, bf_done;
  logic [LG-1:0] addr_a, addr_b;
  logic [LG-2:0] tw_addr;
  logic [31:0]   wdata_a_re, wdata_a_im, wdata_b_re, wdata_b_im;
  logic [31:0]   rdata_a_re, rdata_a_im, rdata_b_re, rdata_b_im;
  logic [31:0]   tw_cos, tw_sin, r1, i1, r2, i2, SIN, COS;
  logic [31:0]   F0R, F0I, F1R, F1I;

  fft_stage_sequencer #(.SIZE(SZ), .BF_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
    .wdata_a_re(wdata_a_re), .wdata_a_im(wdata_a_im),
    .wdata_b_re(wdata_b_re), .wdata_b_im(wdata_b_im),
    .rdata_a_re(rdata_a_re), .rdata_a_im(rdata_a_im),
    .rdata_b_re(rdata_b_re), .rdata_b_im(rdata_b_im),
    .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .r1(r1), .i1(i1), .r2(r2), .i2(i2), .SIN(SIN), .COS(COS),
    .bf_go(bf_go), .bf_done(bf_done),
    .F0R(F0R), .F0I(F0I), .F1R(F1R), .F1I(F1I)
  );

  // ---------------- float helpers ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) begin
      d = {f[31], 63'd0};
    end else begin
      e = {3'd0, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] <= 11'd896) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // F0 = A + W*B, F1 = A - W*B, W = COS + j*SIN
  function automatic logic [127:0] butterfly(input logic [31:0] ar, ai, br, bi, wc, ws);
    real tr, ti;
    tr = f2r(wc) * f2r(br) - f2r(ws) * f2r(bi);
    ti = f2r(wc) * f2r(bi) + f2r(ws) * f2r(br);
    return {r2f(f2r(ar) + tr), r2f(f2r(ai) + ti), r2f(f2r(ar) - tr), r2f(f2r(ai) - ti)};
  endfunction

  // ---------------- sample RAM / twiddle ROM model ----------------
  logic [31:0] ram_re [SZ];
  logic [31:0] ram_im [SZ];
  logic [31:0] rom_cos [SZ/2];
  logic [31:0] rom_sin [SZ/2];
  logic        load_req = 1'b0;
  int          commits = 0;

  initial begin
    for (int m = 0; m < SZ / 2; m++) begin
      rom_cos[m] = r2f($cos(2.0 * 3.14159265358979 * m / SZ));
      rom_sin[m] = r2f(-$sin(2.0 * 3.14159265358979 * m / SZ));
    end
  end

  always @(posedge clk) begin
    rdata_a_re <= ram_re[addr_a];
    rdata_a_im <= ram_im[addr_a];
    rdata_b_re <= ram_re[addr_b];
    rdata_b_im <= ram_im[addr_b];
    tw_cos     <= rom_cos[tw_addr];
    tw_sin     <= rom_sin[tw_addr];
    if (load_req) begin
      // bit-reversed impulse x[0]=1.0 lands at address 0
      for (int i = 0; i < SZ; i++) begin
        ram_re[i] <= (i == 0) ? ONE : 32'd0;
        ram_im[i] <= 32'd0;
      end
    end else begin
      if (we_a) begin
        ram_re[addr_a] <= wdata_a_re;
        ram_im[addr_a] <= wdata_a_im;
      end
      if (we_b) begin
        ram_re[addr_b] <= wdata_b_re;
        ram_im[addr_b] <= wdata_b_im;
      end
      if (we_a || we_b) commits <= commits + 1;
    end
  end

  // ---------------- butterfly model ----------------
  logic stub_on = 1'b1;
  logic spur_en = 1'b0;
  int   lat = 3;
  int   cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      cnt     <= 0;
      bf_done <= 1'b0;
    end else if (bf_go && stub_on) begin
      cnt     <= lat;
      bf_done <= 1'b0;
      {F0R, F0I, F1R, F1I} <= butterfly(r1, i1, r2, i2, COS, SIN);
    end else if (cnt > 1) begin
      cnt     <= cnt - 1;
      bf_done <= 1'b0;
    end else if (cnt == 1) begin
      cnt     <= 0;
      bf_done <= 1'b1;
    end else begin
      bf_done <= spur_en && !bf_go;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] cur = 8'd0;
  int total = 0;
  int bad = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_go_cyc = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected (top, bottom, twiddle) per butterfly, enumerated group by group.
  task automatic push_expected();
    for (int s = 0; s < LG; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < SZ / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          int top, bot, tw;
          top = g * 2 * half + j;
          bot = top + half;
          tw  = j * (SZ / (2 * half));
          exp_q.push_back({3'(top), 3'(bot), 2'(tw)});
        end
      end
    end
  endtask

  // Advance one cycle and check what the DUT shows mid-cycle.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (bf_go) begin
        go_cnt++;
        last_go_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("go_unexpected", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("go_top", 32'(addr_a), 32'(cur[7:5]));
          chk("go_bot", 32'(addr_b), 32'(cur[4:2]));
          chk("go_tw", 32'(tw_addr), 32'(cur[1:0]));
        end
      end
      if (we_a || we_b) begin
        chk("wr_both", 32'(we_a && we_b), 32'd1);
        chk("wr_top", 32'(addr_a), 32'(cur[7:5]));
        chk("wr_bot", 32'(addr_b), 32'(cur[4:2]));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) chk("done_seen", 32'd0, 32'd1);
  endtask

  task automatic load_impulse();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic check_ram();
    for (int i = 0; i < SZ; i++) begin
      chk("ram_re", ram_re[i], ONE);
      chk("ram_im_zero", 32'(f2r(ram_im[i]) == 0.0), 32'd1);
    end
  endtask

  task automatic run_fft(input int l, input logic spur, input int span);
    int c0, g0;
    lat = l;
    load_impulse();
    exp_q.delete();
    push_expected();
    c0 = commits;
    g0 = go_cnt;
    spur_en = spur;
    do_start();
    chk("busy_rise", 32'(busy), 32'd1);
    wait_done(3000);
    spur_en = 1'b0;
    chk("done_span", 32'(done_cyc - t0), 32'(span));
    chk("go_count", 32'(go_cnt - g0), 32'(NBF));
    chk("wr_count", 32'(commits - c0), 32'(NBF));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    check_ram();
  endtask

  typedef struct {
    int   l;
    logic spur;
    int   span;
  } run_vec_t;

  run_vec_t vecs[4];

  initial begin
    int c0, g0, d0, n;
    logic [31:0] cw;
    // latency, spurious bf_done outside WAITBF, start->done distance 1+12*(L+4)
    vecs[0] = '{l: 1, spur: 1'b0, span: 61};
    vecs[1] = '{l: 3, spur: 1'b0, span: 85};
    vecs[2] = '{l: 3, spur: 1'b1, span: 85};
    vecs[3] = '{l: 9, spur: 1'b0, span: 157};

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_outs_or", 32'(|{done, we_a, we_b, bf_go, addr_a, addr_b, tw_addr, r1, i1, r2, i2,
                            SIN, COS, wdata_a_re, wdata_a_im, wdata_b_re, wdata_b_im}), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 4; v++) begin
      run_fft(vecs[v].l, vecs[v].spur, vecs[v].span);
      repeat (3) tick();
    end

    // start held high for the whole run: one FFT only
    lat = 3;
    load_impulse();
    exp_q.delete();
    push_expected();
    d0 = done_cnt;
    g0 = go_cnt;
    start = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    start = 1'b0;
    repeat (40) tick();
    chk("hold_done_once", 32'(done_cnt - d0), 32'd1);
    chk("hold_go_count", 32'(go_cnt - g0), 32'(NBF));
    chk("hold_idle", 32'(busy), 32'd0);
    check_ram();

    // butterfly never answers: timeout, no writes, sticky error
    stub_on = 1'b0;
    load_impulse();
    exp_q.delete();
    push_expected();
    c0 = commits;
    g0 = go_cnt;
    do_start();
    wait_done(200);
    chk("to_span", 32'(done_cyc - last_go_cyc), 32'(TO));
    chk("to_error_at_done", 32'(error), 32'd1);
    chk("to_go_count", 32'(go_cnt - g0), 32'd1);
    repeat (3) tick();
    chk("to_no_writes", 32'(commits - c0), 32'd0);
    chk("to_error_sticky", 32'(error), 32'd1);
    stub_on = 1'b1;
    lat = 2;
    load_impulse();
    exp_q.delete();
    push_expected();
    do_start();
    chk("to_error_cleared", 32'(error), 32'd0);
    wait_done(3000);
    chk("after_to_error", 32'(error), 32'd0);
    check_ram();

    // reset during the first write of stage 1
    lat = 2;
    load_impulse();
    exp_q.delete();
    push_expected();
    c0 = commits;
    do_start();
    n = 0;
    while (!(we_a && (commits - c0) == 4) && n < 500) begin
      tick();
      n++;
    end
    chk("rst_wr_reached", 32'(we_a && (commits - c0) == 4), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr_we_a", 32'(we_a), 32'd0);
    chk("rst_wr_we_b", 32'(we_b), 32'd0);
    cw = 32'(commits);
    tick();
    chk("rst_wr_no_write", 32'(commits), cw);
    chk("rst_wr_busy", 32'(busy), 32'd0);
    chk("rst_wr_outs_or", 32'(|{done, error, we_a, we_b, bf_go, addr_a, addr_b, tw_addr, r1, i1,
                               r2, i2, SIN, COS, wdata_a_re, wdata_a_im, wdata_b_re, wdata_b_im}),
        32'd0);
    rst = 1'b0;
    tick();
    run_fft(3, 1'b0, 85);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
